// File: rtl/line_mirror_engine_pkg.sv
// Shared types and column-mapping helper for the line mirror engine.
package mirror_pkg;

    typedef enum logic [1:0] {
        MODE_PASS     = 2'd0,
        MODE_FLIP_H   = 2'd1,
        MODE_COPY_L2R = 2'd2,
        MODE_COPY_R2L = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_e;

    // Source column for output column x; for odd w the centre column maps to itself.
    function automatic int unsigned mirror_col(input mode_e mode, input int unsigned x,
                                               input int unsigned w);
        int unsigned mid;
        int unsigned r;
        mid = w / 2;
        r   = x;
        case (mode)
            MODE_FLIP_H:   r = w - 1 - x;
            MODE_COPY_L2R: if (x >= mid) r = w - 1 - x;
            MODE_COPY_R2L: if (x < mid)  r = w - 1 - x;
            default:       r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/line_mirror_engine_if.sv
// Pixel write-stream bundle: camera-side write port in, frame-buffer write port out.
interface line_mirror_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned PIX_W  = 16
) ();
    import mirror_pkg::*;

    mode_e             mode_in;
    logic              we_in;
    logic [ADDR_W-1:0] wAddr_in;
    logic [PIX_W-1:0]  wData_in;
    logic              we_out;
    logic [ADDR_W-1:0] wAddr_out;
    logic [PIX_W-1:0]  wData_out;
    logic              busy;
    logic              sync_err;
    logic              overrun;

    modport master (
        output mode_in, we_in, wAddr_in, wData_in,
        input  we_out, wAddr_out, wData_out, busy, sync_err, overrun
    );

    modport slave (
        input  mode_in, we_in, wAddr_in, wData_in,
        output we_out, wAddr_out, wData_out, busy, sync_err, overrun
    );
endinterface

// File: rtl/line_mirror_engine_buf.sv
// Ping-pong line store: writes go to buffer sel, reads come from the other one.
module pingpong_line_buf #(
    parameter  int unsigned DEPTH = 320,
    parameter  int unsigned PIX_W = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_sel,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [PIX_W-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [PIX_W-1:0] o_rdata
);
    logic [PIX_W-1:0] r_mem0 [DEPTH];
    logic [PIX_W-1:0] r_mem1 [DEPTH];

    // Line 0 store write port
    always_ff @(posedge clk) begin
        if (i_we && !i_sel) r_mem0[i_waddr] <= i_wdata;
    end

    // Line 1 store write port
    always_ff @(posedge clk) begin
        if (i_we && i_sel) r_mem1[i_waddr] <= i_wdata;
    end

    assign o_rdata = i_sel ? r_mem0[i_raddr] : r_mem1[i_raddr];
endmodule

// File: rtl/line_mirror_engine.sv
// Horizontal mirror stage: delays the stream by one line and remaps columns per frame mode.
module line_mirror_engine
    import mirror_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 320,
    parameter int unsigned IMG_HEIGHT = 240,
    parameter int unsigned PIX_W      = 16,
    parameter int unsigned ADDR_W     = 17
) (
    input  logic          clk,
    input  logic          reset,
    line_mirror_if.slave  bus
);
    localparam int unsigned       XW         = $clog2(IMG_WIDTH);
    localparam int unsigned       YW         = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0]     X_LAST     = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST     = YW'(IMG_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] A_W        = ADDR_W'(IMG_WIDTH);
    localparam logic [ADDR_W-1:0] A_LAST_ROW = ADDR_W'((IMG_HEIGHT - 1) * IMG_WIDTH);

    logic              r_in_we;
    logic [ADDR_W-1:0] r_in_addr;
    logic [PIX_W-1:0]  r_in_data;
    mode_e             r_in_mode;

    state_e            r_state, w_state_nxt, w_pstate;
    mode_e             r_mode, w_mode_nxt;
    logic [XW-1:0]     r_x, r_d, w_x_nxt, w_d_nxt, w_px, w_col_src, w_col;
    logic [YW-1:0]     r_y, w_y_nxt, w_py;
    logic [ADDR_W-1:0] r_exp, w_exp_nxt, w_pexp, w_emit_addr;
    logic              r_sel, w_sel_nxt;
    logic              w_accept, w_resync, w_emit, w_buf_we, w_sync_set, w_ovr_set;
    logic [PIX_W-1:0]  w_rdata;

    logic              r_we_out, r_busy, r_sync_err, r_overrun;
    logic [ADDR_W-1:0] r_waddr_out;
    logic [PIX_W-1:0]  r_wdata_out;

    assign w_accept  = r_in_we && (r_state != S_DRAIN);
    assign w_resync  = w_accept && (r_in_addr == '0);
    assign w_ovr_set = r_in_we && (r_state == S_DRAIN);

    // Input capture stage
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_in_we   <= 1'b0;
            r_in_addr <= '0;
            r_in_data <= '0;
            r_in_mode <= MODE_PASS;
        end else begin
            r_in_we   <= bus.we_in;
            r_in_addr <= bus.wAddr_in;
            r_in_data <= bus.wData_in;
            r_in_mode <= bus.mode_in;
        end
    end

    // Next-state, position counters, buffer write and emit decode
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_d_nxt     = r_d;
        w_exp_nxt   = r_exp;
        w_sel_nxt   = r_sel;
        w_px        = r_x;
        w_py        = r_y;
        w_pexp      = r_exp;
        w_pstate    = r_state;
        w_emit      = 1'b0;
        w_emit_addr = '0;
        w_buf_we    = 1'b0;
        w_sync_set  = 1'b0;

        // Address 0 restarts the frame at the current pixel
        if (w_resync) begin
            w_px       = '0;
            w_py       = '0;
            w_pexp     = '0;
            w_pstate   = S_FILL;
            w_mode_nxt = r_in_mode;
        end
        w_col_src = w_px;

        if (r_state == S_DRAIN) begin
            w_col_src   = r_d;
            w_emit      = 1'b1;
            w_emit_addr = A_LAST_ROW + ADDR_W'(r_d);
            if (r_d == X_LAST) begin
                w_d_nxt     = '0;
                w_state_nxt = S_FILL;
            end else begin
                w_d_nxt = r_d + XW'(1);
            end
        end else if (w_accept) begin
            w_buf_we    = 1'b1;
            w_sync_set  = !w_resync && (r_in_addr != r_exp);
            w_emit      = (w_pstate == S_STREAM);
            w_emit_addr = w_pexp - A_W;
            w_state_nxt = w_pstate;
            w_exp_nxt   = w_pexp + ADDR_W'(1);
            w_x_nxt     = w_px + XW'(1);
            w_y_nxt     = w_py;
            if (w_px == X_LAST) begin
                w_x_nxt   = '0;
                w_sel_nxt = !r_sel;
                w_y_nxt   = w_py + YW'(1);
                if (w_pstate == S_FILL) begin
                    w_state_nxt = S_STREAM;
                end else if (w_py == Y_LAST) begin
                    w_state_nxt = S_DRAIN;
                    w_y_nxt     = '0;
                    w_exp_nxt   = '0;
                end
            end
        end

        w_col = XW'(mirror_col(r_mode, 32'(w_col_src), IMG_WIDTH));
    end

    // State register and position counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FILL;
            r_mode  <= MODE_PASS;
            r_x     <= '0;
            r_y     <= '0;
            r_d     <= '0;
            r_exp   <= '0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_d     <= w_d_nxt;
            r_exp   <= w_exp_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // Output pipeline register and sticky status flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_we_out    <= 1'b0;
            r_waddr_out <= '0;
            r_wdata_out <= '0;
            r_busy      <= 1'b0;
            r_sync_err  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_we_out   <= w_emit;
            r_busy     <= (w_state_nxt == S_DRAIN);
            r_sync_err <= r_sync_err | w_sync_set;
            r_overrun  <= r_overrun | w_ovr_set;
            if (w_emit) begin
                r_waddr_out <= w_emit_addr;
                r_wdata_out <= w_rdata;
            end
        end
    end

    pingpong_line_buf #(
        .DEPTH (IMG_WIDTH),
        .PIX_W (PIX_W)
    ) u_buf (
        .clk     (clk),
        .i_sel   (r_sel),
        .i_we    (w_buf_we),
        .i_waddr (w_px),
        .i_wdata (r_in_data),
        .i_raddr (w_col),
        .o_rdata (w_rdata)
    );

    assign bus.we_out    = r_we_out;
    assign bus.wAddr_out = r_waddr_out;
    assign bus.wData_out = r_wdata_out;
    assign bus.busy      = r_busy;
    assign bus.sync_err  = r_sync_err;
    assign bus.overrun   = r_overrun;

    a_addr_range: assert property (@(posedge clk) disable iff (!reset)
        r_we_out |-> (32'(r_waddr_out) < 32'(IMG_WIDTH * IMG_HEIGHT)));
endmodule
